// File: rtl/bridge.sv
// AXI-style slave to APB master bridge: a burst of up to 16 beats is buffered,
// then replayed beat by beat over APB (writes) or collected from APB and returned on R (reads).
module bridge (
    input  logic        clk,
    input  logic        arvalid,
    input  logic        res_n,
    input  logic [1:0]  arburst,
    input  logic [3:0]  arlen,
    input  logic [4:0]  araddr,
    output logic        arready,
    output logic [15:0] rdata,
    output logic        rresp,
    output logic        rlast,
    input  logic        rready,
    output logic        rvalid,
    input  logic        awvalid,
    input  logic [4:0]  awaddr,
    output logic        awready,
    input  logic [3:0]  awlen,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    input  logic [15:0] wdata,
    output logic        wready,
    input  logic        wlast,
    input  logic        bready,
    output logic        bvalid,
    output logic        bresp,
    output logic [2:0]  PADDR,
    output logic [15:0] PWDATA,
    input  logic [15:0] PRDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    output logic        PSEL4,
    input  logic        PREADY
);

    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_ACCESS, R_SEND, W_COLLECT, WR_SETUP, WR_ACCESS, B_RESP
    } state_t;

    localparam logic [1:0] MODE_FIXED = 2'b00;
    localparam logic [1:0] MODE_INCR  = 2'b01;
    localparam logic [1:0] MODE_WRAP  = 2'b10;

    state_t      state_reg, state_next;
    logic [4:0]  addr_reg, addr_step;
    logic [3:0]  len_reg, last_reg, idx_reg;
    logic [1:0]  mode_reg;
    logic        resp_reg;
    logic [15:0] buf_mem [16];
    logic [15:0] buf_rd, buf_wdata;
    logic        buf_we;
    logic        beat_last;
    logic        apb_active;
    logic [3:0]  psel_vec;

    // WRAP is only honoured for power-of-two block sizes; anything else degrades to INCR.
    function automatic logic [1:0] burst_mode(input logic [1:0] burst, input logic [3:0] len);
        if (burst == 2'b00)
            return MODE_FIXED;
        if (burst == 2'b10 && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
            return MODE_WRAP;
        return MODE_INCR;
    endfunction

    assign beat_last = (idx_reg == last_reg);
    assign buf_rd    = buf_mem[idx_reg];

    always_comb begin
        addr_step = addr_reg + 5'd1;
        case (mode_reg)
            MODE_FIXED: addr_step = addr_reg;
            MODE_WRAP:  addr_step = (addr_reg & ~{1'b0, len_reg})
                                  | ((addr_reg + 5'd1) & {1'b0, len_reg});
            default:    ;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!res_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (arvalid)
                    state_next = RD_SETUP;
                else if (awvalid)
                    state_next = W_COLLECT;
            end
            RD_SETUP:  state_next = RD_ACCESS;
            RD_ACCESS: if (PREADY) state_next = beat_last ? R_SEND : RD_SETUP;
            R_SEND:    if (rready && beat_last) state_next = IDLE;
            W_COLLECT: if (wvalid && (wlast || idx_reg == len_reg)) state_next = WR_SETUP;
            WR_SETUP:  state_next = WR_ACCESS;
            WR_ACCESS: if (PREADY) state_next = beat_last ? B_RESP : WR_SETUP;
            B_RESP:    if (bready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Burst bookkeeping: address, beat index and the index of the final beat
    always_ff @(posedge clk) begin
        if (!res_n) begin
            addr_reg <= '0;
            len_reg  <= '0;
            last_reg <= '0;
            idx_reg  <= '0;
            mode_reg <= '0;
            resp_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    idx_reg <= '0;
                    if (arvalid) begin
                        addr_reg <= araddr;
                        len_reg  <= arlen;
                        last_reg <= arlen;
                        mode_reg <= burst_mode(arburst, arlen);
                        resp_reg <= (arburst == 2'b11);
                    end else if (awvalid) begin
                        addr_reg <= awaddr;
                        len_reg  <= awlen;
                        last_reg <= awlen;
                        mode_reg <= burst_mode(awburst, awlen);
                        resp_reg <= (awburst == 2'b11);
                    end
                end
                RD_ACCESS, WR_ACCESS: begin
                    if (PREADY) begin
                        if (beat_last) begin
                            idx_reg <= '0;
                        end else begin
                            idx_reg  <= idx_reg + 4'd1;
                            addr_reg <= addr_step;
                        end
                    end
                end
                R_SEND: if (rready) idx_reg <= idx_reg + 4'd1;
                W_COLLECT: begin
                    if (wvalid) begin
                        // An early wlast shortens the burst to the beats actually received.
                        if (wlast || idx_reg == len_reg) begin
                            last_reg <= idx_reg;
                            idx_reg  <= '0;
                        end else begin
                            idx_reg <= idx_reg + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        buf_we    = 1'b0;
        buf_wdata = PRDATA;
        if (res_n) begin
            if (state_reg == RD_ACCESS && PREADY) begin
                buf_we = 1'b1;
            end else if (state_reg == W_COLLECT && wvalid) begin
                buf_we    = 1'b1;
                buf_wdata = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we)
            buf_mem[idx_reg] <= buf_wdata;
    end

    assign apb_active = res_n && (state_reg == RD_SETUP || state_reg == RD_ACCESS ||
                                  state_reg == WR_SETUP || state_reg == WR_ACCESS);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_psel
            assign psel_vec[gi] = apb_active && (addr_reg[4:3] == 2'(gi));
        end
    endgenerate

    assign PSEL1 = psel_vec[0];
    assign PSEL2 = psel_vec[1];
    assign PSEL3 = psel_vec[2];
    assign PSEL4 = psel_vec[3];

    // Output decode; everything is forced low while reset is asserted
    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 1'b0;
        rlast   = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PWRITE  = 1'b0;
        PENABLE = 1'b0;
        if (res_n) begin
            case (state_reg)
                IDLE: begin
                    arready = 1'b1;
                    awready = 1'b1;
                end
                RD_SETUP:  PADDR = addr_reg[2:0];
                RD_ACCESS: begin
                    PADDR   = addr_reg[2:0];
                    PENABLE = 1'b1;
                end
                R_SEND: begin
                    rvalid = 1'b1;
                    rdata  = buf_rd;
                    rresp  = resp_reg;
                    rlast  = beat_last;
                end
                W_COLLECT: wready = 1'b1;
                WR_SETUP: begin
                    PADDR  = addr_reg[2:0];
                    PWRITE = 1'b1;
                    PWDATA = buf_rd;
                end
                WR_ACCESS: begin
                    PADDR   = addr_reg[2:0];
                    PWRITE  = 1'b1;
                    PWDATA  = buf_rd;
                    PENABLE = 1'b1;
                end
                B_RESP: begin
                    bvalid = 1'b1;
                    bresp  = resp_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bridge.sv
// Self-checking bench for bridge: spec vectors from a table, hand-written corner
// sequences, then random bursts checked against an address/memory model of the APB side.
module tb_bridge;
    logic        clk = 1'b0;
    logic        res_n, arvalid, rready, awvalid, wvalid, wlast, bready;
    logic [1:0]  arburst, awburst;
    logic [3:0]  arlen, awlen;
    logic [4:0]  araddr, awaddr;
    logic [15:0] wdata, PRDATA;
    logic        PREADY = 1'b1;
    logic        arready, rresp, rlast, rvalid, awready, wready, bvalid, bresp;
    logic [15:0] rdata, PWDATA;
    logic [2:0]  PADDR;
    logic        PWRITE, PENABLE, PSEL1, PSEL2, PSEL3, PSEL4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bridge dut (
        .clk(clk), .arvalid(arvalid), .res_n(res_n), .arburst(arburst), .arlen(arlen),
        .araddr(araddr), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rready(rready), .rvalid(rvalid), .awvalid(awvalid), .awaddr(awaddr),
        .awready(awready), .awlen(awlen), .awburst(awburst), .wvalid(wvalid),
        .wdata(wdata), .wready(wready), .wlast(wlast), .bready(bready), .bvalid(bvalid),
        .bresp(bresp), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3), .PSEL4(PSEL4),
        .PREADY(PREADY)
    );

    // Four APB peripherals of 8 words each, seen as one 32-word memory
    logic [15:0] mem [32];
    logic [1:0]  apb_sel;
    always_comb apb_sel = PSEL2 ? 2'd1 : PSEL3 ? 2'd2 : PSEL4 ? 2'd3 : 2'd0;
    assign PRDATA = mem[{apb_sel, PADDR}];

    typedef struct {
        logic [4:0]  a;
        logic        wr;
        logic [15:0] d;
    } xfer_t;
    xfer_t apb_q[$];

    logic [4:0]  last_addr [16];
    logic [15:0] last_rdata [16];
    logic [15:0] wbuf [16];
    logic        last_resp;
    int          pready_mode = 0;
    int          acc_cnt = 0;
    logic        prev_en = 1'b0, prev_rdy = 1'b1;
    logic [23:0] prev_bus = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] model_addr(input logic [4:0] s, input logic [3:0] l,
                                              input logic [1:0] b, input int k);
        int sz, st, base;
        sz = int'(l) + 1;
        st = int'(s);
        if (b == 2'b00)
            return s;
        if (b == 2'b10 && (sz == 2 || sz == 4 || sz == 8 || sz == 16)) begin
            base = (st / sz) * sz;
            return 5'(base + (st - base + k) % sz);
        end
        return 5'((st + k) % 32);
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({arready, awready, rvalid, rdata, rresp, rlast, wready, bvalid, bresp,
                    PADDR, PWDATA, PWRITE, PENABLE, PSEL1, PSEL2, PSEL3, PSEL4});
    endfunction

    // APB slave: log every completed transfer, apply writes to the memory
    always @(posedge clk) begin
        if ((PSEL1 | PSEL2 | PSEL3 | PSEL4) && PENABLE && PREADY) begin
            chk("psel_onehot", 64'($countones({PSEL1, PSEL2, PSEL3, PSEL4})), 64'd1);
            apb_q.push_back('{a: {apb_sel, PADDR}, wr: PWRITE, d: PWDATA});
            if (PWRITE)
                mem[{apb_sel, PADDR}] = PWDATA;
        end
    end

    // PREADY driver and check that a stalled ACCESS keeps the bus stable
    always @(negedge clk) begin
        if (PENABLE && prev_en && !prev_rdy)
            chk("apb_hold", 64'({PSEL4, PSEL3, PSEL2, PSEL1, PADDR, PWRITE, PWDATA}), 64'(prev_bus));
        acc_cnt = PENABLE ? acc_cnt + 1 : 0;
        case (pready_mode)
            0:       PREADY = 1'b1;
            1:       PREADY = 1'($urandom);
            default: PREADY = (acc_cnt > 3);
        endcase
        prev_en  = PENABLE;
        prev_rdy = PREADY;
        prev_bus = {PSEL4, PSEL3, PSEL2, PSEL1, PADDR, PWRITE, PWDATA};
    end

    // All phase tasks enter and leave on a falling edge
    task automatic ar_phase(input logic [4:0] a, input logic [3:0] l, input logic [1:0] b);
        int t = 0;
        araddr = a; arlen = l; arburst = b; arvalid = 1'b1;
        while (!arready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ar_handshake", 64'(t < 50), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("ar_to_psel_latency", 64'(PSEL1 | PSEL2 | PSEL3 | PSEL4), 64'd1);
    endtask

    task automatic r_phase(input logic [4:0] a, input logic [3:0] l, input logic [1:0] b,
                           input bit rnd);
        int beat = 0;
        int t = 0;
        while (beat <= int'(l) && t < 3000) begin
            rready = rnd ? 1'($urandom) : 1'b1;
            if (rvalid && rready) begin
                chk("rdata", 64'(rdata), 64'(mem[model_addr(a, l, b, beat)]));
                chk("rresp", 64'(rresp), 64'(b == 2'b11));
                chk("rlast", 64'(rlast), 64'(beat == int'(l)));
                last_rdata[beat] = rdata;
                last_resp = rresp;
                beat++;
            end else if (!rvalid) begin
                chk("r_idle_zero", 64'({rdata, rresp, rlast}), 64'd0);
            end
            @(negedge clk);
            t++;
        end
        rready = 1'b0;
        chk("r_complete", 64'(beat), 64'(int'(l) + 1));
        chk("r_after_last", 64'(rvalid), 64'd0);
    endtask

    task automatic aw_phase(input logic [4:0] a, input logic [3:0] l, input logic [1:0] b);
        int t = 0;
        awaddr = a; awlen = l; awburst = b; awvalid = 1'b1;
        while (!awready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("aw_handshake", 64'(t < 3000), 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
        chk("w_collect_ready", 64'(wready), 64'd1);
    endtask

    task automatic w_phase(input int nbeats, input bit rnd);
        int i = 0;
        int t = 0;
        while (i < nbeats && t < 500) begin
            if (rnd && $urandom_range(0, 2) == 0) begin
                wvalid = 1'b0;
            end else begin
                wvalid = 1'b1;
                wdata  = wbuf[i];
                wlast  = (i == nbeats - 1);
            end
            if (wvalid && wready)
                i++;
            @(negedge clk);
            t++;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        chk("w_complete", 64'(i), 64'(nbeats));
    endtask

    task automatic b_phase(input logic [1:0] b, input bit rnd);
        int t = 0;
        int cnt = 0;
        bit done = 1'b0;
        while (!done && t < 3000) begin
            bready = rnd ? 1'($urandom) : 1'b1;
            if (bvalid)
                cnt++;
            if (bvalid && bready) begin
                chk("bresp", 64'(bresp), 64'(b == 2'b11));
                last_resp = bresp;
                done = 1'b1;
            end
            @(negedge clk);
            t++;
        end
        bready = 1'b0;
        chk("b_done", 64'(done), 64'd1);
        chk("b_cleared", 64'(bvalid), 64'd0);
        if (!rnd)
            chk("b_one_cycle", 64'(cnt), 64'd1);
    endtask

    task automatic check_apb(input logic [4:0] a, input logic [3:0] l, input logic [1:0] b,
                             input int nbeats, input bit wr);
        chk("apb_count", 64'(apb_q.size()), 64'(nbeats));
        for (int k = 0; k < nbeats && k < apb_q.size(); k++) begin
            last_addr[k] = apb_q[k].a;
            chk("apb_addr", 64'(apb_q[k].a), 64'(model_addr(a, l, b, k)));
            chk("apb_pwrite", 64'(apb_q[k].wr), 64'(wr));
            if (wr)
                chk("apb_pwdata", 64'(apb_q[k].d), 64'(wbuf[k]));
        end
        apb_q.delete();
    endtask

    task automatic do_read(input logic [4:0] a, input logic [3:0] l, input logic [1:0] b,
                           input bit rnd);
        $display("[TB] read  addr=%0d len=%0d burst=%0d", a, l, b);
        ar_phase(a, l, b);
        r_phase(a, l, b, rnd);
        check_apb(a, l, b, int'(l) + 1, 1'b0);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] l, input logic [1:0] b,
                            input int nbeats, input bit rnd);
        $display("[TB] write addr=%0d len=%0d burst=%0d beats=%0d", a, l, b, nbeats);
        aw_phase(a, l, b);
        w_phase(nbeats, rnd);
        b_phase(b, rnd);
        check_apb(a, l, b, nbeats, 1'b1);
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  a;
        logic [3:0]  l;
        logic [1:0]  b;
        logic [3:0][4:0] ea;
        bit          eresp;
    } vec_t;

    vec_t vec [10];

    initial begin
        vec[0] = '{1'b0, 5'd9,  4'd3, 2'b01, {5'd12, 5'd11, 5'd10, 5'd9},  1'b0};
        vec[1] = '{1'b1, 5'd9,  4'd3, 2'b01, {5'd12, 5'd11, 5'd10, 5'd9},  1'b0};
        vec[2] = '{1'b0, 5'd6,  4'd3, 2'b10, {5'd5,  5'd4,  5'd7,  5'd6},  1'b0};
        vec[3] = '{1'b0, 5'd31, 4'd1, 2'b00, {5'd0,  5'd0,  5'd31, 5'd31}, 1'b0};
        vec[4] = '{1'b0, 5'd7,  4'd1, 2'b01, {5'd0,  5'd0,  5'd8,  5'd7},  1'b0};
        vec[5] = '{1'b0, 5'd20, 4'd2, 2'b11, {5'd0,  5'd22, 5'd21, 5'd20}, 1'b1};
        vec[6] = '{1'b0, 5'd6,  4'd2, 2'b10, {5'd0,  5'd8,  5'd7,  5'd6},  1'b0};
        vec[7] = '{1'b0, 5'd30, 4'd7, 2'b10, {5'd25, 5'd24, 5'd31, 5'd30}, 1'b0};
        vec[8] = '{1'b1, 5'd31, 4'd1, 2'b01, {5'd0,  5'd0,  5'd0,  5'd31}, 1'b0};
        vec[9] = '{1'b1, 5'd17, 4'd3, 2'b11, {5'd20, 5'd19, 5'd18, 5'd17}, 1'b1};

        res_n = 1'b0; arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        wlast = 1'b0; bready = 1'b0; arburst = '0; awburst = '0; arlen = '0; awlen = '0;
        araddr = '0; awaddr = '0; wdata = '0;
        for (int i = 0; i < 32; i++)
            mem[i] = 16'($urandom);
        mem[9] = 16'd10; mem[10] = 16'd17; mem[11] = 16'd25; mem[12] = 16'd30;

        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        res_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'({arready, awready, rvalid, bvalid, wready}), 64'b11000);

        // Spec vectors
        for (int v = 0; v < 10; v++) begin
            if (vec[v].wr) begin
                for (int k = 0; k < 16; k++)
                    wbuf[k] = 16'($urandom);
                if (v == 1) begin
                    wbuf[0] = 16'hFFFF; wbuf[1] = 16'h1111; wbuf[2] = 16'h2222; wbuf[3] = 16'h3333;
                end
                do_write(vec[v].a, vec[v].l, vec[v].b, int'(vec[v].l) + 1, 1'b0);
            end else begin
                do_read(vec[v].a, vec[v].l, vec[v].b, 1'b0);
            end
            for (int k = 0; k <= int'(vec[v].l) && k < 4; k++)
                chk("vec_addr", 64'(last_addr[k]), 64'(vec[v].ea[k]));
            chk("vec_resp", 64'(last_resp), 64'(vec[v].eresp));
            if (v == 0) begin
                chk("vec0_rdata0", 64'(last_rdata[0]), 64'd10);
                chk("vec0_rdata1", 64'(last_rdata[1]), 64'd17);
                chk("vec0_rdata2", 64'(last_rdata[2]), 64'd25);
                chk("vec0_rdata3", 64'(last_rdata[3]), 64'd30);
            end
        end

        // PREADY held low for three ACCESS cycles on every beat
        pready_mode = 2;
        do_read(5'd7, 4'd1, 2'b01, 1'b0);
        chk("stall_addr1", 64'(last_addr[1]), 64'd8);
        pready_mode = 0;

        // AR and AW valid in the same IDLE cycle: read runs to completion first
        $display("[TB] concurrent read addr=12 len=2 / write addr=3 len=1");
        for (int k = 0; k < 16; k++)
            wbuf[k] = 16'($urandom);
        awaddr = 5'd3; awlen = 4'd1; awburst = 2'b01; awvalid = 1'b1;
        ar_phase(5'd12, 4'd2, 2'b01);
        chk("aw_blocked_during_read", 64'(awready), 64'd0);
        r_phase(5'd12, 4'd2, 2'b01, 1'b0);
        check_apb(5'd12, 4'd2, 2'b01, 3, 1'b0);
        aw_phase(5'd3, 4'd1, 2'b01);
        w_phase(2, 1'b0);
        b_phase(2'b01, 1'b0);
        check_apb(5'd3, 4'd1, 2'b01, 2, 1'b1);

        // Reset while a read beat is stalled in ACCESS
        $display("[TB] reset during read access");
        pready_mode = 2;
        ar_phase(5'd9, 4'd3, 2'b01);
        @(negedge clk);
        chk("rst_in_access", 64'(PENABLE), 64'd1);
        res_n = 1'b0;
        @(negedge clk);
        chk("rst_outputs_mid", all_outs(), 64'd0);
        res_n = 1'b1;
        @(negedge clk);
        chk("rst_release_arready", 64'(arready), 64'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 30; i++) begin
                if (rvalid)
                    seen++;
                @(negedge clk);
            end
            chk("rst_no_rvalid", 64'(seen), 64'd0);
        end
        chk("rst_no_apb_beat", 64'(apb_q.size()), 64'd0);
        apb_q.delete();
        pready_mode = 0;

        // Random bursts with random PREADY and handshake back-pressure
        pready_mode = 1;
        for (int n = 0; n < 40; n++) begin
            logic [4:0] a;
            logic [3:0] l;
            logic [1:0] b;
            int nb;
            a = 5'($urandom);
            l = 4'($urandom);
            b = 2'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 16; k++)
                    wbuf[k] = 16'($urandom);
                nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(l) + 1)) : int'(l) + 1;
                do_write(a, l, b, nb, 1'b1);
            end else begin
                do_read(a, l, b, 1'b1);
            end
        end
        pready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
